fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_pc_reg.sv | 29 ++
 rtl/fetch_controller.sv | 118 +++++++++++
 tb/tb_fetch_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and RISC-V instruction constants.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT,
    ST_ERROR
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_RESET
  } pc_op_e;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with hold, +4 increment, target load and vector reload.
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  pc_op_e      op,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_VECTOR;
    end else begin
      case (op)
        PC_INC:   pc <= pc + 32'd4;
        PC_LOAD:  pc <= load_pc;
        PC_RESET: pc <= RESET_VECTOR;
        default:  pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch stage: IDLE/RUN/HALT/ERROR sequencer, IF/ID register and
// issue counter; instruction memory sits outside on imem_addr/imem_instr.
module fetch_controller
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int          WORD_QUANTITY = 256,
  parameter int          BIT_SIZE      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  // The memory aliases on addr[BIT_SIZE+1:2]; the two sizing parameters must agree.
  if (BIT_SIZE != $clog2(WORD_QUANTITY)) begin : g_size_check
    $error("fetch_controller: BIT_SIZE must equal log2(WORD_QUANTITY)");
  end

  fetch_state_e state, state_next;
  pc_op_e       pc_op;
  logic [31:0]  pc;
  logic         issue;
  logic         bubble;
  logic         set_halt;
  logic         set_err;

  fetch_pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk    (clk),
    .reset_n(reset_n),
    .op     (pc_op),
    .load_pc(redirect_pc),
    .pc     (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_op      = PC_HOLD;
    issue      = 1'b0;
    bubble     = 1'b0;
    set_halt   = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_op = PC_RESET;
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Redirect outranks both stall and EBREAK detection.
        if (redirect_valid) begin
          bubble = 1'b1;
          if (is_word_aligned(redirect_pc[1:0])) begin
            pc_op = PC_LOAD;
          end else begin
            set_err    = 1'b1;
            state_next = ST_ERROR;
          end
        end else if (!stall) begin
          issue = 1'b1;
          pc_op = PC_INC;
          if (imem_instr == INSTR_EBREAK) begin
            set_halt   = 1'b1;
            state_next = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (!stall) bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_valid    <= 1'b0;
      if_pc       <= 32'h0000_0000;
      if_instr    <= INSTR_NOP;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_count <= 32'h0000_0000;
    end else begin
      if (issue) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem_instr;
        if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
      end else if (bubble) begin
        if_valid <= 1'b0;
      end
      if (set_halt) halted    <= 1'b1;
      if (set_err)  fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a combinational instruction memory model.
module tb_fetch_controller;

  localparam int          WORD_QUANTITY = 256;
  localparam int          BIT_SIZE      = 8;
  localparam logic [31:0] NOP           = 32'h0000_0013;
  localparam logic [31:0] EBREAK        = 32'h0010_0073;
  localparam logic [31:0] ADDI          = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;
  logic        fetch_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [WORD_QUANTITY];
  int          n_checks = 0;
  int          n_fail   = 0;

  assign imem_instr = mem[imem_addr[BIT_SIZE+1:2]];

  always #5 clk = ~clk;

  fetch_controller #(
    .RESET_VECTOR (32'h0000_0000),
    .WORD_QUANTITY(WORD_QUANTITY),
    .BIT_SIZE     (BIT_SIZE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .halted        (halted),
    .fetch_err     (fetch_err),
    .fetch_count   (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst if_valid", {31'b0, if_valid}, 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst if_pc", if_pc, 32'h0);
    check("rst if_instr", if_instr, NOP);
    check("rst halted", {31'b0, halted}, 32'h0);
    check("rst fetch_err", {31'b0, fetch_err}, 32'h0);
    check("rst fetch_count", fetch_count, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start imem_addr", imem_addr, 32'h0);
    check("start if_valid", {31'b0, if_valid}, 32'h0);
  endtask

  initial begin
    reset_n        = 1'b1;
    start          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < WORD_QUANTITY; i++) mem[i] = NOP;
    mem[32'h40 >> 2] = ADDI;
    #2;
    apply_reset();

    // Idle ignores stall=0 and redirect without start.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check("idle hold addr", imem_addr, 32'h0);
    check("idle count", fetch_count, 32'h0);
    do_start();

    // Sequential fetch of NOPs; if_pc trails imem_addr by one cycle.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("seq if_pc", if_pc, 32'(k * 4));
      check("seq imem_addr", imem_addr, 32'((k + 1) * 4));
      check("seq if_valid", {31'b0, if_valid}, 32'h1);
    end
    check("seq count3", fetch_count, 32'd3);

    tick();
    check("pre-stall addr", imem_addr, 32'h10);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall if_pc", if_pc, 32'h0C);
      check("stall addr", imem_addr, 32'h10);
      check("stall count", fetch_count, 32'd4);
    end
    stall = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("release if_pc", if_pc, 32'h10);
    check("release addr", imem_addr, 32'h14);
    check("release count", fetch_count, 32'd5);

    // Redirect wins over stall and inserts one bubble.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    stall          = 1'b1;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check("redir if_valid", {31'b0, if_valid}, 32'h0);
    check("redir addr", imem_addr, 32'h40);
    check("redir count", fetch_count, 32'd5);
    tick();
    check("redir if_pc", if_pc, 32'h40);
    check("redir if_instr", if_instr, ADDI);
    check("redir valid", {31'b0, if_valid}, 32'h1);
    check("redir addr+4", imem_addr, 32'h44);

    // EBREAK at word 3; a redirect on the same cycle suppresses the halt.
    mem[3] = EBREAK;
    apply_reset();
    do_start();
    for (int k = 0; k < 3; k++) tick();
    check("eb pre addr", imem_addr, 32'h0C);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("eb redir halted", {31'b0, halted}, 32'h0);
    check("eb redir addr", imem_addr, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    check("eb if_pc", if_pc, 32'h0C);
    check("eb if_instr", if_instr, EBREAK);
    check("eb halted", {31'b0, halted}, 32'h1);
    check("eb valid", {31'b0, if_valid}, 32'h1);
    check("eb addr", imem_addr, 32'h10);
    check("eb count", fetch_count, 32'd7);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("halt stall valid", {31'b0, if_valid}, 32'h1);
    tick();
    check("halt clear valid", {31'b0, if_valid}, 32'h0);
    check("halt addr", imem_addr, 32'h10);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("halt start addr", imem_addr, 32'h10);
    check("halt start valid", {31'b0, if_valid}, 32'h0);
    check("halt start count", fetch_count, 32'd7);
    check("halt still", {31'b0, halted}, 32'h1);

    // Misaligned redirect: sticky error until reset.
    mem[3] = NOP;
    apply_reset();
    do_start();
    tick();
    tick();
    check("err pre addr", imem_addr, 32'h08);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    check("err flag", {31'b0, fetch_err}, 32'h1);
    check("err valid", {31'b0, if_valid}, 32'h0);
    check("err addr", imem_addr, 32'h08);
    redirect_pc = 32'h80;
    start       = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b0;
    start          = 1'b0;
    tick();
    check("err sticky", {31'b0, fetch_err}, 32'h1);
    check("err addr hold", imem_addr, 32'h08);
    check("err count hold", fetch_count, 32'd2);
    check("err valid hold", {31'b0, if_valid}, 32'h0);
    #2;
    apply_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
